// File: rtl/tcp_rx_reader_pkg.sv
// Shared types for the TCP RX reader: metadata layouts, bus widths, FSM states.
package tcp_rx_reader_pkg;

    localparam int unsigned AXI_NET_BITS  = 512;
    localparam int unsigned AXI_KEEP_BITS = AXI_NET_BITS / 8;
    localparam int unsigned POPCNT_BITS   = 7;
    localparam int unsigned SID_BITS      = 16;
    localparam int unsigned LEN_BITS      = 16;
    localparam int unsigned BYTE_CNT_BITS = 17;
    localparam int unsigned DROP_CNT_BITS = 16;
    localparam int unsigned CHUNK_CNT_BITS = 32;
    localparam int unsigned NOTIFY_BITS   = 88;
    localparam int unsigned RD_PKG_BITS   = 40;
    localparam int unsigned RX_META_BITS  = 16;

    typedef struct packed {
        logic [6:0]          rsvd;
        logic                closed;
        logic [15:0]         dst_port;
        logic [31:0]         ip;
        logic [LEN_BITS-1:0] len;
        logic [SID_BITS-1:0] sid;
    } tcp_notify_t;

    typedef struct packed {
        logic [7:0]          rsvd;
        logic [LEN_BITS-1:0] len;
        logic [SID_BITS-1:0] sid;
    } tcp_rd_pkg_t;

    typedef struct packed {
        logic [SID_BITS-1:0] sid;
    } tcp_rx_meta_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_META,
        S_DATA
    } rx_state_t;

    // Size of the next read request: whatever remains, capped at the maximum.
    function automatic logic [LEN_BITS-1:0] chunk_len(input logic [LEN_BITS-1:0] rem,
                                                      input logic [LEN_BITS-1:0] max_rd);
        return (rem > max_rd) ? max_rd : rem;
    endfunction

endpackage

// File: rtl/tcp_rx_reader_if.sv
// Valid/ready metadata channel and AXI4-Stream bundle used on the reader ports.
interface metaIntf #(
    parameter int unsigned DATA_BITS = 32
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

interface AXI4S #(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned ID_BITS   = 16
);
    localparam int unsigned KEEP_BITS = DATA_BITS / 8;

    logic [DATA_BITS-1:0] tdata;
    logic [KEEP_BITS-1:0] tkeep;
    logic                 tlast;
    logic [ID_BITS-1:0]   tid;
    logic                 tvalid;
    logic                 tready;

    modport m (output tdata, output tkeep, output tlast, output tid, output tvalid, input tready);
    modport s (input tdata, input tkeep, input tlast, input tid, input tvalid, output tready);
endinterface

// File: rtl/tcp_rx_reader_keep_popcount.sv
// Combinational count of set bits in a 64-bit tkeep (0..64).
module tcp_keep_popcount
    import tcp_rx_reader_pkg::*;
(
    input  logic [AXI_KEEP_BITS-1:0] keep_i,
    output logic [POPCNT_BITS-1:0]   cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < AXI_KEEP_BITS; i++) begin
            cnt_o = cnt_o + POPCNT_BITS'(keep_i[i]);
        end
    end

endmodule

// File: rtl/tcp_rx_reader.sv
// User-side TCP receive engine: turns session notifications into chunked reads
// and forwards each chunk's payload as one tagged AXI4S packet.
module tcp_rx_reader
    import tcp_rx_reader_pkg::*;
#(
    parameter int unsigned MAX_RD = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    metaIntf.s                        s_tcp_notify,
    metaIntf.m                        m_tcp_rd_pkg,
    metaIntf.s                        s_tcp_rx_meta,
    AXI4S.s                           s_axis_tcp_rx,
    AXI4S.m                           m_axis_rx,
    output logic                      err_sid,
    output logic                      err_len,
    output logic [DROP_CNT_BITS-1:0]  cnt_drop,
    output logic [CHUNK_CNT_BITS-1:0] cnt_chunk
);

    localparam logic [LEN_BITS-1:0] MAX_RD_W = LEN_BITS'(MAX_RD);

    rx_state_t                 state_q, state_d;
    logic [SID_BITS-1:0]       sid_q, sid_d;
    logic [LEN_BITS-1:0]       rem_q, rem_d;
    logic [LEN_BITS-1:0]       chunk_q, chunk_d;
    logic [BYTE_CNT_BITS-1:0]  byte_cnt_q, byte_cnt_d;
    tcp_rd_pkg_t               rd_pkg_q, rd_pkg_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      notify_rdy_q, notify_rdy_d;
    logic                      meta_rdy_q, meta_rdy_d;
    logic                      err_sid_q, err_sid_d;
    logic                      err_len_q, err_len_d;
    logic [DROP_CNT_BITS-1:0]  cnt_drop_q, cnt_drop_d;
    logic [CHUNK_CNT_BITS-1:0] cnt_chunk_q, cnt_chunk_d;

    tcp_notify_t               notify_c;
    tcp_rx_meta_t              meta_c;
    logic [POPCNT_BITS-1:0]    pop_c;
    logic [BYTE_CNT_BITS-1:0]  beat_total_c;
    logic                      in_data_c;
    logic                      notify_hs_c;
    logic                      rd_hs_c;
    logic                      meta_hs_c;
    logic                      beat_hs_c;
    logic                      unused_ok;

    assign notify_c = tcp_notify_t'(s_tcp_notify.data);
    assign meta_c   = tcp_rx_meta_t'(s_tcp_rx_meta.data);

    tcp_keep_popcount u_popcount (
        .keep_i (s_axis_tcp_rx.tkeep),
        .cnt_o  (pop_c)
    );

    assign in_data_c    = (state_q == S_DATA);
    assign notify_hs_c  = s_tcp_notify.valid & notify_rdy_q;
    assign rd_hs_c      = rd_valid_q & m_tcp_rd_pkg.ready;
    assign meta_hs_c    = s_tcp_rx_meta.valid & meta_rdy_q;
    assign beat_hs_c    = in_data_c & s_axis_tcp_rx.tvalid & m_axis_rx.tready;
    assign beat_total_c = byte_cnt_q + BYTE_CNT_BITS'(pop_c);

    // Zero-latency payload path, gated so nothing moves outside DATA.
    assign m_axis_rx.tdata      = s_axis_tcp_rx.tdata;
    assign m_axis_rx.tkeep      = s_axis_tcp_rx.tkeep;
    assign m_axis_rx.tlast      = s_axis_tcp_rx.tlast;
    assign m_axis_rx.tid        = sid_q;
    assign m_axis_rx.tvalid     = in_data_c & s_axis_tcp_rx.tvalid;
    assign s_axis_tcp_rx.tready = in_data_c & m_axis_rx.tready;

    assign s_tcp_notify.ready  = notify_rdy_q;
    assign s_tcp_rx_meta.ready = meta_rdy_q;
    assign m_tcp_rd_pkg.valid  = rd_valid_q;
    assign m_tcp_rd_pkg.data   = rd_pkg_q;

    assign err_sid   = err_sid_q;
    assign err_len   = err_len_q;
    assign cnt_drop  = cnt_drop_q;
    assign cnt_chunk = cnt_chunk_q;

    assign unused_ok = ^{notify_c.ip, notify_c.dst_port, notify_c.rsvd, s_axis_tcp_rx.tid};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            sid_q        <= '0;
            rem_q        <= '0;
            chunk_q      <= '0;
            byte_cnt_q   <= '0;
            rd_pkg_q     <= '0;
            rd_valid_q   <= 1'b0;
            notify_rdy_q <= 1'b1;
            meta_rdy_q   <= 1'b0;
            err_sid_q    <= 1'b0;
            err_len_q    <= 1'b0;
            cnt_drop_q   <= '0;
            cnt_chunk_q  <= '0;
        end else begin
            state_q      <= state_d;
            sid_q        <= sid_d;
            rem_q        <= rem_d;
            chunk_q      <= chunk_d;
            byte_cnt_q   <= byte_cnt_d;
            rd_pkg_q     <= rd_pkg_d;
            rd_valid_q   <= rd_valid_d;
            notify_rdy_q <= notify_rdy_d;
            meta_rdy_q   <= meta_rdy_d;
            err_sid_q    <= err_sid_d;
            err_len_q    <= err_len_d;
            cnt_drop_q   <= cnt_drop_d;
            cnt_chunk_q  <= cnt_chunk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sid_d       = sid_q;
        rem_d       = rem_q;
        chunk_d     = chunk_q;
        byte_cnt_d  = byte_cnt_q;
        rd_pkg_d    = rd_pkg_q;
        err_sid_d   = err_sid_q;
        err_len_d   = err_len_q;
        cnt_drop_d  = cnt_drop_q;
        cnt_chunk_d = cnt_chunk_q;

        unique case (state_q)
            S_IDLE: begin
                if (notify_hs_c) begin
                    if (notify_c.closed || (notify_c.len == '0)) begin
                        cnt_drop_d = cnt_drop_q + DROP_CNT_BITS'(1);
                    end else begin
                        sid_d         = notify_c.sid;
                        rem_d         = notify_c.len;
                        rd_pkg_d.rsvd = '0;
                        rd_pkg_d.sid  = notify_c.sid;
                        rd_pkg_d.len  = chunk_len(notify_c.len, MAX_RD_W);
                        state_d       = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (rd_hs_c) begin
                    chunk_d = rd_pkg_q.len;
                    rem_d   = rem_q - rd_pkg_q.len;
                    state_d = S_META;
                end
            end
            S_META: begin
                if (meta_hs_c) begin
                    if (meta_c.sid != sid_q) begin
                        err_sid_d = 1'b1;
                    end
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_hs_c) begin
                    if (s_axis_tcp_rx.tlast) begin
                        if (beat_total_c != BYTE_CNT_BITS'(chunk_q)) begin
                            err_len_d = 1'b1;
                        end
                        byte_cnt_d  = '0;
                        cnt_chunk_d = cnt_chunk_q + CHUNK_CNT_BITS'(1);
                        // A drained session returns to IDLE rather than issuing a zero-length read.
                        if (rem_q != '0) begin
                            rd_pkg_d.rsvd = '0;
                            rd_pkg_d.sid  = sid_q;
                            rd_pkg_d.len  = chunk_len(rem_q, MAX_RD_W);
                            state_d       = S_REQ;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        byte_cnt_d = beat_total_c;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        notify_rdy_d = (state_d == S_IDLE);
        meta_rdy_d   = (state_d == S_META);
        rd_valid_d   = (state_d == S_REQ);
    end

endmodule

// File: tb/tb_tcp_rx_reader.sv
// Randomized bench for tcp_rx_reader: plays the TCP stack and the application sink.
module tb_tcp_rx_reader;
    import tcp_rx_reader_pkg::*;

    localparam int unsigned MAX_RD = 1024;
    localparam int unsigned BUDGET = 64;

    typedef struct packed {
        logic [AXI_NET_BITS-1:0]  data;
        logic [AXI_KEEP_BITS-1:0] keep;
        logic                     last;
        logic [SID_BITS-1:0]      tid;
    } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic err_sid, err_len;
    logic [15:0] cnt_drop;
    logic [31:0] cnt_chunk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_drop = 0;
    int exp_chunk = 0;
    bit exp_err_sid = 1'b0;
    bit exp_err_len = 1'b0;
    bit sink_rand = 1'b0;
    beat_t exp_q[$];

    always #5 aclk = ~aclk;

    metaIntf #(.DATA_BITS(NOTIFY_BITS))  notify_if ();
    metaIntf #(.DATA_BITS(RD_PKG_BITS))  rd_if ();
    metaIntf #(.DATA_BITS(RX_META_BITS)) meta_if ();
    AXI4S    #(.DATA_BITS(AXI_NET_BITS)) axis_in ();
    AXI4S    #(.DATA_BITS(AXI_NET_BITS)) axis_out ();

    tcp_rx_reader #(.MAX_RD(MAX_RD)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_tcp_notify  (notify_if),
        .m_tcp_rd_pkg  (rd_if),
        .s_tcp_rx_meta (meta_if),
        .s_axis_tcp_rx (axis_in),
        .m_axis_rx     (axis_out),
        .err_sid       (err_sid),
        .err_len       (err_len),
        .cnt_drop      (cnt_drop),
        .cnt_chunk     (cnt_chunk)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AXI_KEEP_BITS-1:0] keep_mask(input int n);
        logic [AXI_KEEP_BITS-1:0] k = '0;
        int c = 0;
        if (n >= AXI_KEEP_BITS) return '1;
        while (c < n) begin
            int i = $urandom_range(0, AXI_KEEP_BITS - 1);
            if (!k[i]) begin
                k[i] = 1'b1;
                c++;
            end
        end
        return k;
    endfunction

    function automatic logic [AXI_NET_BITS-1:0] rnd_data();
        logic [AXI_NET_BITS-1:0] r;
        for (int i = 0; i < AXI_NET_BITS / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Application sink: optionally random backpressure.
    always @(negedge aclk) axis_out.tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    // Output scoreboard: every delivered beat must match the next beat the stack sent.
    always @(negedge aclk) begin
        #2;
        if (!areset && axis_out.tvalid && axis_out.tready) begin
            if (exp_q.size() == 0) begin
                chk("rx_extra_beat", 64'd1, 64'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("rx_tdata", 64'(axis_out.tdata == e.data), 64'd1);
                chk("rx_tkeep", axis_out.tkeep, e.keep);
                chk("rx_tlast", 64'(axis_out.tlast), 64'(e.last));
                chk("rx_tid", 64'(axis_out.tid), 64'(e.tid));
            end
        end
    end

    task automatic do_notify(input logic [15:0] sid, input logic [15:0] len, input logic closed);
        bit got = 1'b0;
        notify_if.valid = 1'b1;
        notify_if.data  = {7'd0, closed, 16'($urandom), 32'($urandom), len, sid};
        for (int k = 0; k < BUDGET; k++) begin
            #2;
            if (notify_if.ready) begin
                got = 1'b1;
                @(negedge aclk);
                break;
            end
            @(negedge aclk);
        end
        notify_if.valid = 1'b0;
        chk("notify_hs", 64'(got), 64'd1);
    endtask

    task automatic do_rd(input logic [15:0] sid, input logic [15:0] len);
        logic [39:0] word;
        int hold;
        #2;
        chk("rd_latency", 64'(rd_if.valid), 64'd1);
        word = rd_if.data;
        chk("rd_sid", 64'(word[15:0]), 64'(sid));
        chk("rd_len", 64'(word[31:16]), 64'(len));
        chk("rd_rsvd", 64'(word[39:32]), 64'd0);
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            #2;
            chk("rd_hold", 64'(rd_if.valid && (rd_if.data == word)), 64'd1);
        end
        @(negedge aclk);
        rd_if.ready = 1'b1;
        #2;
        chk("rd_valid_at_hs", 64'(rd_if.valid), 64'd1);
        @(negedge aclk);
        rd_if.ready = 1'b0;
    endtask

    task automatic do_chunk(input logic [15:0] sid, input logic [15:0] ret_sid, input int nbytes);
        int nb = (nbytes + AXI_KEEP_BITS - 1) / AXI_KEEP_BITS;
        beat_t beats[$];
        bit early;
        for (int b = 0; b < nb; b++) begin
            beat_t t;
            t.data = rnd_data();
            t.last = (b == nb - 1);
            t.keep = t.last ? keep_mask(nbytes - b * AXI_KEEP_BITS) : '1;
            t.tid  = sid;
            beats.push_back(t);
            exp_q.push_back(t);
        end
        meta_if.valid = 1'b1;
        meta_if.data  = ret_sid;
        early = 1'($urandom_range(0, 1));
        if (early) begin
            axis_in.tdata  = beats[0].data;
            axis_in.tkeep  = beats[0].keep;
            axis_in.tlast  = beats[0].last;
            axis_in.tvalid = 1'b1;
        end
        #2;
        chk("meta_latency", 64'(meta_if.ready), 64'd1);
        if (early) chk("early_beat_held", 64'({axis_in.tready, axis_out.tvalid}), 64'd0);
        @(negedge aclk);
        meta_if.valid = 1'b0;
        foreach (beats[b]) begin
            bit got = 1'b0;
            axis_in.tdata  = beats[b].data;
            axis_in.tkeep  = beats[b].keep;
            axis_in.tlast  = beats[b].last;
            axis_in.tvalid = 1'b1;
            for (int k = 0; k < BUDGET; k++) begin
                #2;
                if (axis_in.tready) begin
                    got = 1'b1;
                    @(negedge aclk);
                    break;
                end
                @(negedge aclk);
            end
            axis_in.tvalid = 1'b0;
            chk("beat_hs", 64'(got), 64'd1);
            if (!beats[b].last && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge aclk);
        end
    endtask

    task automatic chk_status();
        chk("cnt_chunk", 64'(cnt_chunk), 64'(exp_chunk));
        chk("cnt_drop", 64'(cnt_drop), 64'(16'(exp_drop)));
        chk("err_sid", 64'(err_sid), 64'(exp_err_sid));
        chk("err_len", 64'(err_len), 64'(exp_err_len));
    endtask

    // One notification end to end; the chunk split is derived here from len and MAX_RD.
    task automatic do_session(input logic [15:0] sid, input logic [15:0] len, input logic closed,
                              input logic [15:0] sid_flip, input int delta);
        int rem;
        do_notify(sid, len, closed);
        if (closed || len == 0) begin
            exp_drop++;
            #2;
            chk("drop_stays_idle", 64'({notify_if.ready, rd_if.valid}), 64'b10);
            chk_status();
            @(negedge aclk);
            return;
        end
        rem = int'(len);
        while (rem > 0) begin
            int c = (rem > int'(MAX_RD)) ? int'(MAX_RD) : rem;
            int nbytes = (c + delta < 1) ? c + 1 : c + delta;
            rem -= c;
            do_rd(sid, 16'(c));
            do_chunk(sid, sid ^ sid_flip, nbytes);
            exp_chunk++;
            if (sid_flip != 0) exp_err_sid = 1'b1;
            if (nbytes != c) exp_err_len = 1'b1;
        end
        #2;
        chk("back_to_idle", 64'({notify_if.ready, rd_if.valid, axis_out.tvalid}), 64'b100);
        chk_status();
        @(negedge aclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        notify_if.valid = 1'b0;
        notify_if.data  = '0;
        rd_if.ready     = 1'b0;
        meta_if.valid   = 1'b0;
        meta_if.data    = '0;
        axis_in.tvalid  = 1'b0;
        axis_in.tdata   = '0;
        axis_in.tkeep   = '0;
        axis_in.tlast   = 1'b0;
        axis_in.tid     = '0;

        repeat (3) @(negedge aclk);
        #2;
        chk("rst_notify_ready", 64'(notify_if.ready), 64'd1);
        chk("rst_valids", 64'({rd_if.valid, meta_if.ready, axis_out.tvalid, axis_in.tready}), 64'd0);
        chk("rst_rd_data", 64'(rd_if.data), 64'd0);
        chk("rst_tid", 64'(axis_out.tid), 64'd0);
        chk_status();
        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        do_session(16'd5, 16'd100, 1'b0, 16'd0, 0);
        do_session(16'd7, 16'd2500, 1'b0, 16'd0, 0);
        do_session(16'd8, 16'd50, 1'b1, 16'd0, 0);
        do_session(16'd9, 16'd0, 1'b0, 16'd0, 0);
        sink_rand = 1'b1;
        do_session(16'd10, 16'd1024, 1'b0, 16'd0, 0);
        do_session(16'd3, 16'd64, 1'b0, 16'd10, 0);
        do_session(16'd12, 16'd100, 1'b0, 16'd0, -4);

        for (int s = 0; s < 20; s++) begin
            int r = $urandom_range(0, 19);
            int sel = $urandom_range(0, 3);
            logic [15:0] len;
            logic [15:0] flip;
            int delta;
            len   = (sel == 0) ? 16'd1 : (sel == 1) ? 16'(MAX_RD) : (sel == 2) ? 16'(2 * MAX_RD)
                                                                 : 16'($urandom_range(1, 4000));
            if (r == 1) len = 16'd0;
            flip  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
            delta = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) != 0) ? 1 : -1) : 0;
            do_session(16'($urandom), len, 1'(r == 0), flip, delta);
        end

        // Reset in the middle of a two-beat chunk.
        sink_rand = 1'b0;
        do_notify(16'h0011, 16'd128, 1'b0);
        do_rd(16'h0011, 16'd128);
        meta_if.valid = 1'b1;
        meta_if.data  = 16'h0011;
        @(negedge aclk);
        meta_if.valid = 1'b0;
        begin
            beat_t t;
            t.data = rnd_data();
            t.keep = '1;
            t.last = 1'b0;
            t.tid  = 16'h0011;
            exp_q.push_back(t);
            axis_in.tdata  = t.data;
            axis_in.tkeep  = t.keep;
            axis_in.tlast  = 1'b0;
            axis_in.tvalid = 1'b1;
        end
        #2;
        chk("mid_beat0_ready", 64'(axis_in.tready), 64'd1);
        @(negedge aclk);
        axis_in.tdata = rnd_data();
        axis_in.tlast = 1'b1;
        #1;
        areset = 1'b1;
        #1;
        chk("mid_rst_valids", 64'({rd_if.valid, meta_if.ready, axis_out.tvalid, axis_in.tready}), 64'd0);
        chk("mid_rst_notify_ready", 64'(notify_if.ready), 64'd1);
        chk("mid_rst_rd_data", 64'(rd_if.data), 64'd0);
        chk("mid_rst_tid", 64'(axis_out.tid), 64'd0);
        exp_chunk = 0;
        exp_drop = 0;
        exp_err_sid = 1'b0;
        exp_err_len = 1'b0;
        chk_status();
        axis_in.tvalid = 1'b0;
        chk("mid_rst_queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        do_session(16'h0042, 16'd300, 1'b0, 16'd0, 0);

        repeat (4) @(negedge aclk);
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
